envelope_gen: RTL and testbench

ADSR amplitude envelope stage between the `waveshaper` and the `pwm` stage of the synth datapath. Each new 8-bit unsigned waveshaper sample is scaled by an internally generated 8-bit envelope level and forwarded to `pwm`. The envelope is triggered by the key gate from `keypad_encoder` (any key held) and advances on a prescaled tick. Envelope state is also exported for debug LEDs.

---
 rtl/envelope_gen_if.sv | 24 ++
 rtl/envelope_gen.sv | 133 +++++++++++++
 tb/tb_envelope_gen.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/envelope_gen_if.sv
// Sample/gate bundle between waveshaper, keypad gate, envelope stage and pwm.
// Carries the gate, the strobed input sample, the scaled output sample and debug state.
// No backpressure: strobes are one-cycle pulses that are always accepted.
interface envelope_gen_if;
  logic       gate_i;
  logic [7:0] sample_i;
  logic       sample_strobe_i;
  logic [7:0] sample_o;
  logic       sample_valid_o;
  logic [7:0] env_level_o;
  logic [2:0] env_state_o;

  // Envelope stage side
  modport slave (
    input  gate_i, sample_i, sample_strobe_i,
    output sample_o, sample_valid_o, env_level_o, env_state_o
  );

  // Driver / observer side
  modport master (
    output gate_i, sample_i, sample_strobe_i,
    input  sample_o, sample_valid_o, env_level_o, env_state_o
  );
endinterface

// File: rtl/envelope_gen.sv
// ADSR envelope: scales each unsigned sample around midpoint 128 by an 8-bit level.
// Latency: sample_o/sample_valid_o one cycle after sample_strobe_i; level/state registered.
// Backpressure: none, every strobe (including back-to-back) produces its own output.
module envelope_gen #(
  parameter int RATE_DIV    = 12000,
  parameter int ATTACK_INC  = 8,
  parameter int DECAY_DEC   = 2,
  parameter int SUSTAIN_LVL = 160,
  parameter int RELEASE_DEC = 4
) (
  input  logic           clk,
  input  logic           reset,
  envelope_gen_if.slave  bus
);

  localparam int            CW      = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(RATE_DIV - 1);

  // Decay stops at this level or below; sum fits in 9 bits (max 510)
  localparam logic [8:0] DEC_FLOOR = 9'(SUSTAIN_LVL) + 9'(DECAY_DEC);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ATTACK  = 3'd1,
    S_DECAY   = 3'd2,
    S_SUSTAIN = 3'd3,
    S_RELEASE = 3'd4
  } state_t;

  logic [CW-1:0] cnt_q;
  logic          tick;
  logic          gate_q;
  logic          rise;
  state_t        state_q;
  logic [7:0]    level_q;
  logic [7:0]    sample_q;
  logic          valid_q;

  logic [8:0]         att_sum;
  logic signed [8:0]  diff;
  logic signed [16:0] prod;
  logic [8:0]         shifted;
  logic [7:0]         scaled_d;
  logic               unused_prod_bits;

  assign tick = (cnt_q == CNT_MAX);
  assign rise = bus.gate_i & ~gate_q;

  // Free-running tick prescaler, independent of gate activity
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     cnt_q <= '0;
    else if (tick) cnt_q <= '0;
    else           cnt_q <= cnt_q + CW'(1);
  end

  // Gate history for rise detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) gate_q <= 1'b0;
    else       gate_q <= bus.gate_i;
  end

  assign att_sum = {1'b0, level_q} + 9'(ATTACK_INC);

  // Envelope FSM: rise beats gate-low beats tick; level is held on event cycles
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      level_q <= 8'd0;
    end else if (rise) begin
      state_q <= S_ATTACK;
    end else if (!bus.gate_i &&
                 (state_q == S_ATTACK || state_q == S_DECAY || state_q == S_SUSTAIN)) begin
      state_q <= S_RELEASE;
    end else if (tick) begin
      case (state_q)
        S_ATTACK: begin
          if (att_sum >= 9'd255) begin
            level_q <= 8'd255;
            state_q <= S_DECAY;
          end else begin
            level_q <= att_sum[7:0];
          end
        end
        S_DECAY: begin
          if ({1'b0, level_q} <= DEC_FLOOR) begin
            level_q <= 8'(SUSTAIN_LVL);
            state_q <= S_SUSTAIN;
          end else begin
            level_q <= level_q - 8'(DECAY_DEC);
          end
        end
        S_SUSTAIN: ;
        S_RELEASE: begin
          if ({1'b0, level_q} <= 9'(RELEASE_DEC)) begin
            level_q <= 8'd0;
            state_q <= S_IDLE;
          end else begin
            level_q <= level_q - 8'(RELEASE_DEC);
          end
        end
        default: begin
          level_q <= 8'd0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // Signed scaling around the midpoint; floor rounding via arithmetic shift
  assign diff     = $signed({1'b0, bus.sample_i}) - 9'sd128;
  assign prod     = $signed({{8{diff[8]}}, diff}) * $signed({9'b0, level_q});
  assign shifted  = prod[16:8];
  assign scaled_d = shifted[7:0] + 8'd128;
  // Result is always 0..254, so the top shifted bit and the fraction are not needed
  assign unused_prod_bits = ^{prod[7:0], shifted[8]};

  // Output sample register: captures on strobe, holds otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_q <= 8'd128;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= bus.sample_strobe_i;
      if (bus.sample_strobe_i) sample_q <= scaled_d;
    end
  end

  assign bus.sample_o       = sample_q;
  assign bus.sample_valid_o = valid_q;
  assign bus.env_level_o    = level_q;
  assign bus.env_state_o    = state_q;

endmodule

// File: tb/tb_envelope_gen.sv
// Directed bench for envelope_gen with a fast prescaler (RATE_DIV=4).
// Expected levels, states, tick spacing and scaled samples are hand-computed constants.
// Every wait on the DUT is bounded; a timeout shows up as a failed comparison.
module tb_envelope_gen;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  envelope_gen_if bus ();

  envelope_gen #(
    .RATE_DIV   (4),
    .ATTACK_INC (64),
    .DECAY_DEC  (16),
    .SUSTAIN_LVL(128),
    .RELEASE_DEC(32)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Wait (bounded) until the level changes; returns negedges waited, 0 on timeout
  task automatic wait_change(output int ncyc);
    logic [7:0] prev;
    prev = bus.env_level_o;
    ncyc = 0;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (bus.env_level_o !== prev) begin
        ncyc = i;
        break;
      end
    end
  endtask

  // Wait (bounded) until the FSM reaches a given state
  task automatic wait_state(input logic [2:0] st);
    for (int i = 0; i < 100; i++) begin
      if (bus.env_state_o === st) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    bus.gate_i = 1'b0;
    bus.sample_i = 8'd0;
    bus.sample_strobe_i = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.env_level_o !== 8'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", bus.env_level_o); end
    checks++; if (bus.env_state_o !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", bus.env_state_o); end
    checks++; if (bus.sample_o !== 8'd128) begin errors++; $display("FAIL rst_sample: got %0d want 128", bus.sample_o); end
    checks++; if (bus.sample_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", bus.sample_valid_o); end
    // Gate high on the release edge is a rise
    reset = 1'b0;
    bus.gate_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd1) begin errors++; $display("FAIL rel_attack_state: got %0d want 1", bus.env_state_o); end
    wait_change(n);
    checks++; if (n !== 3) begin errors++; $display("FAIL first_tick_delay: got %0d want 3", n); end
    checks++; if (bus.env_level_o !== 8'd64) begin errors++; $display("FAIL first_tick_level: got %0d want 64", bus.env_level_o); end
    // Level 64, sample 255: 127*64=8128 >>8 = 31 -> 159
    bus.sample_i = 8'd255;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    checks++; if (bus.sample_o !== 8'd159 || bus.sample_valid_o !== 1'b1) begin errors++; $display("FAIL pre_rst_sample: got %0d/%0b want 159/1", bus.sample_o, bus.sample_valid_o); end
    // Asynchronous reset mid-attack, between clock edges
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.env_level_o !== 8'd0) begin errors++; $display("FAIL async_level: got %0d want 0", bus.env_level_o); end
    checks++; if (bus.env_state_o !== 3'd0) begin errors++; $display("FAIL async_state: got %0d want 0", bus.env_state_o); end
    checks++; if (bus.sample_o !== 8'd128) begin errors++; $display("FAIL async_sample: got %0d want 128", bus.sample_o); end
    checks++; if (bus.sample_valid_o !== 1'b0) begin errors++; $display("FAIL async_valid: got %0b want 0", bus.sample_valid_o); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd1 || bus.env_level_o !== 8'd0) begin errors++; $display("FAIL rerelease_attack: got st%0d lvl%0d want st1 lvl0", bus.env_state_o, bus.env_level_o); end
    wait_change(n);
    checks++; if (n !== 3 || bus.env_level_o !== 8'd64) begin errors++; $display("FAIL rerelease_tick: got n%0d lvl%0d want n3 lvl64", n, bus.env_level_o); end
    checks++; if (bus.sample_valid_o !== 1'b0) begin errors++; $display("FAIL valid_after_rst: got %0b want 0", bus.sample_valid_o); end
  endtask

  task automatic test_attack_decay();
    int n;
    logic [7:0] exp_lvl [11] = '{8'd128, 8'd192, 8'd255, 8'd239, 8'd223, 8'd207,
                                 8'd191, 8'd175, 8'd159, 8'd143, 8'd128};
    logic [2:0] exp_st  [11] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2,
                                 3'd2, 3'd2, 3'd2, 3'd2, 3'd3};
    for (int i = 0; i < 11; i++) begin
      wait_change(n);
      checks++;
      if (n !== 4 || bus.env_level_o !== exp_lvl[i] || bus.env_state_o !== exp_st[i]) begin
        errors++;
        $display("FAIL ad_step%0d: got n%0d lvl%0d st%0d want n4 lvl%0d st%0d",
                 i, n, bus.env_level_o, bus.env_state_o, exp_lvl[i], exp_st[i]);
      end
    end
    // Sustain holds for 12 ticks
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      checks++;
      if (bus.env_level_o !== 8'd128 || bus.env_state_o !== 3'd3) begin
        errors++;
        $display("FAIL sustain_hold%0d: got lvl%0d st%0d want lvl128 st3", i, bus.env_level_o, bus.env_state_o);
      end
    end
  endtask

  task automatic test_strobe_timing();
    // Level 128: 255->191, 0->64, 200->164
    logic [7:0] smp [3] = '{8'd255, 8'd0, 8'd200};
    logic [7:0] exp [3] = '{8'd191, 8'd64, 8'd164};
    bus.sample_strobe_i = 1'b1;
    bus.sample_i = smp[0];
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i < 2) bus.sample_i = smp[i+1];
      else       bus.sample_strobe_i = 1'b0;
      checks++;
      if (bus.sample_valid_o !== 1'b1 || bus.sample_o !== exp[i]) begin
        errors++;
        $display("FAIL b2b%0d: got %0d/%0b want %0d/1", i, bus.sample_o, bus.sample_valid_o, exp[i]);
      end
    end
    bus.sample_i = 8'd7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.sample_valid_o !== 1'b0 || bus.sample_o !== 8'd164) begin
        errors++;
        $display("FAIL b2b_hold%0d: got %0d/%0b want 164/0", i, bus.sample_o, bus.sample_valid_o);
      end
    end
  endtask

  task automatic test_release();
    int n;
    logic [7:0] exp_lvl [4] = '{8'd96, 8'd64, 8'd32, 8'd0};
    logic [2:0] exp_st  [4] = '{3'd4, 3'd4, 3'd4, 3'd0};
    bus.gate_i = 1'b0;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd4 || bus.env_level_o !== 8'd128) begin errors++; $display("FAIL rel_enter: got st%0d lvl%0d want st4 lvl128", bus.env_state_o, bus.env_level_o); end
    for (int i = 0; i < 4; i++) begin
      wait_change(n);
      checks++;
      if ((i > 0 && n !== 4) || n == 0 || bus.env_level_o !== exp_lvl[i] || bus.env_state_o !== exp_st[i]) begin
        errors++;
        $display("FAIL rel_step%0d: got n%0d lvl%0d st%0d want lvl%0d st%0d",
                 i, n, bus.env_level_o, bus.env_state_o, exp_lvl[i], exp_st[i]);
      end
    end
    repeat (8) @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd0 || bus.env_level_o !== 8'd0) begin errors++; $display("FAIL idle_hold: got st%0d lvl%0d want st0 lvl0", bus.env_state_o, bus.env_level_o); end
  endtask

  task automatic test_retrigger();
    int n;
    // Climb to 128 from idle
    bus.gate_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd1) begin errors++; $display("FAIL rt_start: got st%0d want 1", bus.env_state_o); end
    wait_change(n);
    wait_change(n);
    checks++; if (bus.env_level_o !== 8'd128) begin errors++; $display("FAIL rt_climb: got %0d want 128", bus.env_level_o); end
    // Release down to 64, then retrigger off-tick
    bus.gate_i = 1'b0;
    @(negedge clk);
    wait_change(n);
    wait_change(n);
    checks++; if (n !== 4 || bus.env_level_o !== 8'd64 || bus.env_state_o !== 3'd4) begin errors++; $display("FAIL rt_rel64: got n%0d lvl%0d st%0d want n4 lvl64 st4", n, bus.env_level_o, bus.env_state_o); end
    bus.gate_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd1 || bus.env_level_o !== 8'd64) begin errors++; $display("FAIL rt_hold: got st%0d lvl%0d want st1 lvl64", bus.env_state_o, bus.env_level_o); end
    wait_change(n);
    checks++; if (n !== 3 || bus.env_level_o !== 8'd128 || bus.env_state_o !== 3'd1) begin errors++; $display("FAIL rt_next: got n%0d lvl%0d st%0d want n3 lvl128 st1", n, bus.env_level_o, bus.env_state_o); end
    // Release to 64 again, then retrigger exactly in the tick cycle
    bus.gate_i = 1'b0;
    @(negedge clk);
    wait_change(n);
    wait_change(n);
    checks++; if (bus.env_level_o !== 8'd64) begin errors++; $display("FAIL rt2_rel64: got %0d want 64", bus.env_level_o); end
    repeat (3) @(negedge clk);
    checks++; if (bus.env_level_o !== 8'd64 || bus.env_state_o !== 3'd4) begin errors++; $display("FAIL rt2_pre: got lvl%0d st%0d want lvl64 st4", bus.env_level_o, bus.env_state_o); end
    bus.gate_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.env_state_o !== 3'd1 || bus.env_level_o !== 8'd64) begin errors++; $display("FAIL rt2_tick_hold: got st%0d lvl%0d want st1 lvl64", bus.env_state_o, bus.env_level_o); end
    wait_change(n);
    checks++; if (n !== 4 || bus.env_level_o !== 8'd128) begin errors++; $display("FAIL rt2_next: got n%0d lvl%0d want n4 lvl128", n, bus.env_level_o); end
  endtask

  task automatic test_scaling();
    int n;
    wait_change(n);
    wait_change(n);
    checks++; if (bus.env_level_o !== 8'd255 || bus.env_state_o !== 3'd2) begin errors++; $display("FAIL sc_reach255: got lvl%0d st%0d want lvl255 st2", bus.env_level_o, bus.env_state_o); end
    bus.sample_i = 8'd255;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_i = 8'd0;
    checks++; if (bus.sample_o !== 8'd254 || bus.sample_valid_o !== 1'b1) begin errors++; $display("FAIL sc_255_255: got %0d/%0b want 254/1", bus.sample_o, bus.sample_valid_o); end
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    checks++; if (bus.sample_o !== 8'd0 || bus.sample_valid_o !== 1'b1) begin errors++; $display("FAIL sc_255_0: got %0d/%0b want 0/1", bus.sample_o, bus.sample_valid_o); end
    @(negedge clk);
    checks++; if (bus.sample_valid_o !== 1'b0) begin errors++; $display("FAIL sc_pulse1: got %0b want 0", bus.sample_valid_o); end
    wait_state(3'd3);
    checks++; if (bus.env_state_o !== 3'd3 || bus.env_level_o !== 8'd128) begin errors++; $display("FAIL sc_sustain: got st%0d lvl%0d want st3 lvl128", bus.env_state_o, bus.env_level_o); end
    bus.sample_i = 8'd255;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    checks++; if (bus.sample_o !== 8'd191 || bus.sample_valid_o !== 1'b1) begin errors++; $display("FAIL sc_128_255: got %0d/%0b want 191/1", bus.sample_o, bus.sample_valid_o); end
    bus.gate_i = 1'b0;
    @(negedge clk);
    wait_state(3'd0);
    checks++; if (bus.env_state_o !== 3'd0 || bus.env_level_o !== 8'd0) begin errors++; $display("FAIL sc_idle: got st%0d lvl%0d want st0 lvl0", bus.env_state_o, bus.env_level_o); end
    bus.sample_i = 8'd77;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    checks++; if (bus.sample_o !== 8'd128 || bus.sample_valid_o !== 1'b1) begin errors++; $display("FAIL sc_0_77: got %0d/%0b want 128/1", bus.sample_o, bus.sample_valid_o); end
    @(negedge clk);
    checks++; if (bus.sample_valid_o !== 1'b0 || bus.sample_o !== 8'd128) begin errors++; $display("FAIL sc_pulse2: got %0d/%0b want 128/0", bus.sample_o, bus.sample_valid_o); end
  endtask

  initial begin
    test_reset();
    test_attack_decay();
    test_strobe_timing();
    test_release();
    test_retrigger();
    test_scaling();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
